// File: rtl/quant_pkg.sv
// quant_pkg: shared component encoding and default sizing for the quantizer scheduler
package quant_pkg;
    typedef enum logic [1:0] {COMP_Y = 2'd0, COMP_CB = 2'd1, COMP_CR = 2'd2} comp_t;
    localparam int DEF_LATENCY = 4;
    localparam int DEF_BUF_DEPTH = 4;
endpackage

// File: rtl/quant_scheduler_if.sv
// quant_scheduler_if: request, quantizer-control, result-buffer and drain signals of the scheduler
import quant_pkg::*;
interface quant_scheduler_if #(parameter int BUF_DEPTH = DEF_BUF_DEPTH);
    localparam int AW = $clog2(BUF_DEPTH);
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic          q_enable;
    logic [1:0]    q_sel;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic [AW-1:0] buf_rd_addr;
    logic          out_valid;
    logic [1:0]    out_comp;
    logic          out_ready;
    logic          flush;
    logic          drain_done;
    logic [AW:0]   occupancy;
    modport master (
        output req_valid, out_ready, flush,
        input  req_ready, q_enable, q_sel, buf_wr_en, buf_wr_addr, buf_rd_addr,
               out_valid, out_comp, drain_done, occupancy
    );
    modport slave (
        input  req_valid, out_ready, flush,
        output req_ready, q_enable, q_sel, buf_wr_en, buf_wr_addr, buf_rd_addr,
               out_valid, out_comp, drain_done, occupancy
    );
endinterface

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: three-way round-robin grant; priority rotates to the slot after each winner
module rr_arbiter3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       en,
    output logic [2:0] gnt,
    output logic [1:0] sel
);
    logic [1:0] ptr, p1, p2, win;
    always_comb begin
        p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
        p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        win = req[ptr] ? ptr : req[p1] ? p1 : p2;
        gnt = en && req != 3'b000 ? 3'b001 << win : 3'b000;
        sel = gnt != 3'b000 ? win : 2'd0;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= 2'd0;
        else if (gnt != 3'b000) ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
    end
endmodule

// File: rtl/quant_scheduler.sv
// quant_scheduler: credit-limited round-robin issue to a shared quantizer with a tag pipeline and result FIFO
import quant_pkg::*;
module quant_scheduler #(
    parameter int LATENCY   = DEF_LATENCY,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input logic clk,
    input logic rst,
    quant_scheduler_if.slave bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int OW = AW + 1;
    localparam int IW = $clog2(LATENCY + 1);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    logic [0:0]         state;
    logic [LATENCY-1:0] vld;
    comp_t              pipe [LATENCY];
    comp_t              tag [BUF_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [OW-1:0]      occ;
    logic [IW-1:0]      inflight;
    logic [2:0]         gnt;
    logic [1:0]         sel;
    logic               issue_ok, issue, push, pop, done;
    rr_arbiter3 u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .en  (issue_ok),
        .gnt (gnt),
        .sel (sel)
    );
    // credit uses registered counts only, so a pop frees a slot one cycle later
    always_comb begin
        issue_ok = state == RUN && (int'(inflight) + int'(occ)) < BUF_DEPTH;
        issue = gnt != 3'b000;
        push = vld[LATENCY-1];
        pop = occ != '0 && bus.out_ready;
        done = state == DRAIN && inflight == '0 && occ == '0;
    end
    assign bus.req_ready   = gnt;
    assign bus.q_enable    = issue;
    assign bus.q_sel       = sel;
    assign bus.buf_wr_en   = push;
    assign bus.buf_wr_addr = wr_ptr;
    assign bus.buf_rd_addr = rd_ptr;
    assign bus.out_valid   = occ != '0;
    assign bus.out_comp    = tag[rd_ptr];
    assign bus.drain_done  = done;
    assign bus.occupancy   = occ;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            vld <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ <= '0;
            inflight <= '0;
            for (int k = 0; k < LATENCY; k++) pipe[k] <= COMP_Y;
            for (int k = 0; k < BUF_DEPTH; k++) tag[k] <= COMP_Y;
        end else begin
            state <= state == RUN ? (bus.flush ? DRAIN : RUN) : (done ? RUN : DRAIN);
            vld[0] <= issue;
            pipe[0] <= comp_t'(sel);
            for (int k = 1; k < LATENCY; k++) begin
                vld[k] <= vld[k-1];
                pipe[k] <= pipe[k-1];
            end
            inflight <= inflight + IW'(issue) - IW'(push);
            occ <= occ + OW'(push) - OW'(pop);
            if (push) begin
                tag[wr_ptr] <= pipe[LATENCY-1];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule
